// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: ID-stage instruction in, registered EX copy and hazard status out.
// The slave modport is the pipeline register's view; master is the driver/observer side.
interface id_ex_reg_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [XLEN-1:0]   id_rd1;
  logic [XLEN-1:0]   id_rd2;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rd1;
  logic [XLEN-1:0]   ex_rd2;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;

  logic              hazard_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  stall, flush,
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
    input  id_rd1, id_rd2, id_imm, id_ctrl,
    output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
    output hazard_stall, bubble_cnt
  );

  modport master (
    output stall, flush,
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
    output id_rd1, id_rd2, id_imm, id_ctrl,
    input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
    input  hazard_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency 1 cycle; stall holds EX, a load-use hit inserts one bubble and holds IF/ID and PC.
module id_ex_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_reg_if.slave  bus
);
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_payload_t;

  ex_payload_t      ex_q;
  ex_payload_t      ex_nxt;
  ex_payload_t      id_payload;
  logic             ex_valid_q;
  logic             ex_valid_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             load_use;

  // A load in EX whose destination the ID instruction reads cannot be forwarded in time.
  always_comb begin
    rs1_hit  = bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd);
    rs2_hit  = bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd);
    load_use = ex_valid_q && ex_q.ctrl[CTRL_MEMREAD] && (ex_q.rd != 5'd0) &&
               bus.id_valid && (rs1_hit || rs2_hit);
  end

  always_comb begin
    id_payload.pc   = bus.id_pc;
    id_payload.rd1  = bus.id_rd1;
    id_payload.rd2  = bus.id_rd2;
    id_payload.imm  = bus.id_imm;
    id_payload.rs1  = bus.id_rs1;
    id_payload.rs2  = bus.id_rs2;
    id_payload.rd   = bus.id_rd;
    id_payload.ctrl = bus.id_ctrl;
    // x0 is hardwired; never let a write to it reach WB.
    if (bus.id_rd == 5'd0) begin
      id_payload.ctrl[CTRL_REGWRITE] = 1'b0;
    end
  end

  always_comb begin
    ex_valid_nxt = ex_valid_q;
    ex_nxt       = ex_q;
    cnt_inc      = 1'b0;
    if (bus.flush) begin
      ex_valid_nxt = 1'b0;
      ex_nxt       = '0;
    end else if (bus.stall) begin
      ex_valid_nxt = ex_valid_q;
      ex_nxt       = ex_q;
    end else if (load_use) begin
      ex_valid_nxt = 1'b0;
      ex_nxt       = '0;
      cnt_inc      = 1'b1;
    end else if (!bus.id_valid) begin
      ex_valid_nxt = 1'b0;
      ex_nxt       = '0;
    end else begin
      ex_valid_nxt = 1'b1;
      ex_nxt       = id_payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_nxt;
      ex_q       <= ex_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_inc && !(&cnt_q)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_rd1       = ex_q.rd1;
  assign bus.ex_rd2       = ex_q.rd2;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.hazard_stall = load_use && !bus.flush;
  assign bus.bubble_cnt   = cnt_q;
endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the pipelined RISC-V core. It sits directly downstream of the register file.
- Each rising clk it captures the register-file read data (RD1/RD2) together with the decoded fields and control bundle of the ID-stage instruction, and presents them to EX.
- It contains the load-use hazard detector: it inserts a bubble and tells IF/ID and the PC to hold.
- It keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- CTRL_W, 12, control-bundle width. Bits [4:0] are defined under Behaviour; the rest are opaque pass-through.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  downstream hold request; EX must not advance.
- flush  in  1  kill the ID-stage instruction (taken branch/jump resolved in EX).
- id_valid  in  1  ID stage holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_use_rs1, id_use_rs2  in  1 each  the instruction actually reads rs1/rs2.
- id_rd1, id_rd2  in  XLEN each  register-file read data (RD1/RD2).
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  decoded control bundle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN each  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices, for forwarding.
- ex_ctrl  out  CTRL_W  registered control.
- hazard_stall  out  1  combinational; IF/ID and PC hold when 1.
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted.

Behaviour:
- Reset:
  - Asynchronous: rst=1 immediately clears every registered output and bubble_cnt to 0, with ex_valid=0.
  - Reset asserted mid-operation discards the EX contents.
- ctrl bit map:
  - [0] regWrite, [1] memRead, [2] memWrite, [3] branch, [4] jump.
  - Bits [CTRL_W-1:5] are passed through unchanged.
- Register-file timing:
  - The register file writes on the falling edge, so RD1/RD2 sampled at the rising edge already reflect a same-cycle WB write.
  - No WB bypass exists in this block.
- load_use (combinational) = ex_valid & ex_ctrl[1] & (ex_rd!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- hazard_stall = load_use & ~flush. A flushed ID instruction never stalls the front end.
- Bubble: ex_valid=0 and ex_ctrl=0; all data/index fields are also zeroed.
- Rising-edge action, in priority order:
  - 1. flush=1: load bubble. Flush wins over stall and over load_use.
  - 2. stall=1: hold all ex_* outputs and bubble_cnt unchanged.
  - 3. load_use=1: load bubble; bubble_cnt += 1.
  - 4. id_valid=0: load bubble; bubble_cnt unchanged.
  - 5. Otherwise: load all id_* fields; ex_valid=1.
- x0 rule: when loading with id_rd==0, ex_ctrl[0] is forced to 0; all other bits load normally.
- bubble_cnt saturates at all-ones; it never wraps.
- Latency:
  - ID-to-EX is exactly 1 cycle when not stalled.
  - A load-use stall costs exactly 1 bubble. On the next edge the load sits in MEM, so load_use deasserts and the held ID instruction loads.
- Back-to-back hazards: each cycle with load_use=1 (and no flush or stall) inserts one bubble and increments the counter once.

Test Plan:
- Reset:
  - Drive valid traffic, assert rst between clock edges → all ex_* = 0, ex_valid = 0 and bubble_cnt = 0 immediately, before the next edge.
  - Deassert rst → the first edge loads normally.
- Plain load:
  - id_valid=1, id_pc=0x100, id_rd1=0xDEADBEEF, id_rd2=5, id_imm=0xFFFFFFFC, id_ctrl=0x001, id_rd=3 → after 1 edge the same values appear on ex_*, with ex_valid=1.
- Load-use:
  - EX holds lw x5 (ctrl=0x003, ex_rd=5); ID is add x6,x5,x1 with id_use_rs1=1 → hazard_stall=1.
  - Next edge: ex_valid=0, ex_ctrl=0, bubble_cnt=1.
  - Following edge: the add loads with ex_rd=6.
  - Repeat with ex_rd=0 → no stall.
- Flush priority:
  - load_use condition true, flush=1 and stall=1 in the same cycle → hazard_stall=0.
  - Next edge: bubble loaded, bubble_cnt unchanged.
- Stall hold:
  - stall=1 for 3 edges while id_* values change → ex_* and bubble_cnt remain constant.
  - Release stall → the current id_* values load on the next edge.
- x0 and saturation:
  - Load id_rd=0, id_ctrl=0x003 → ex_ctrl=0x002.
  - With CNT_W=2, force 5 load-use bubbles → bubble_cnt sequence 1, 2, 3, 3, 3.
